// File: rtl/fetch_buffer_pkg.sv
// Shared pipeline definitions: fetch FSM encoding and the canonical NOP word.
package fetch_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue of {pc, inst} entries with a registered occupancy count.
module fetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clr,
  input  logic                   i_push,
  input  logic [31:0]            i_push_pc,
  input  logic [31:0]            i_push_inst,
  input  logic                   i_pop,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_valid,
  output logic [31:0]            o_head_pc,
  output logic [31:0]            o_head_inst
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [31:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_inst_mem [DEPTH];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !i_clr) begin
      r_pc_mem[r_wr_ptr]   <= i_push_pc;
      r_inst_mem[r_wr_ptr] <= i_push_inst;
    end
  end

  assign o_count     = r_count;
  assign o_valid     = (r_count != '0);
  assign o_head_pc   = o_valid ? r_pc_mem[r_rd_ptr]   : '0;
  assign o_head_inst = o_valid ? r_inst_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch: issues sequential fetches into a small queue, redirects on flush.
//   IDLE | no request outstanding (queue full or just redirected)
//   WAIT | request outstanding, returned word will be queued
//   DROP | request outstanding, returned word is stale and discarded
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic [31:0] i_flush_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_data,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst,
  input  logic        i_ready
);

  localparam int             CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  FULL    = CW'(DEPTH);
  localparam logic [CW-1:0]  FULL_M1 = CW'(DEPTH - 1);

  fetch_state_e  r_state;
  fetch_state_e  w_state_nxt;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_next_pc;
  logic          w_load;
  logic          w_pop;
  logic          w_push;
  logic          w_room;
  logic [CW-1:0] w_count;

  assign w_pop  = valid && i_ready && !i_flush;
  assign w_push = (r_state == ST_WAIT) && i_mem_ack && !i_flush;
  // Space left after this cycle's push (and optional pop): count + 1 - pop < DEPTH.
  assign w_room = w_pop ? (w_count < FULL) : (w_count < FULL_M1);

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clr       (i_flush),
    .i_push      (w_push),
    .i_push_pc   (r_mem_addr),
    .i_push_inst (i_mem_data),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_valid     (valid),
    .o_head_pc   (pc),
    .o_head_inst (inst)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!i_flush && (w_count < FULL)) begin
          w_state_nxt = ST_WAIT;
          w_load      = 1'b1;
        end
      end
      ST_WAIT: begin
        if (i_flush) begin
          w_state_nxt = i_mem_ack ? ST_IDLE : ST_DROP;
        end else if (i_mem_ack) begin
          if (w_room) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (i_mem_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_mem_addr <= '0;
      r_next_pc  <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      if (i_flush) begin
        r_next_pc <= i_flush_pc;
      end else if (w_load) begin
        r_mem_addr <= r_next_pc;
        r_next_pc  <= r_next_pc + 32'd4;
      end
    end
  end

  assign mem_req  = (r_state != ST_IDLE);
  assign mem_addr = r_mem_addr;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus a randomized run vs a queue model.
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst, flush, ack, ready, mem_req, valid;
  logic [31:0] flush_pc, data, mem_addr, pc, inst;

  logic        rst_w, flush_w, ack_w, ready_w, mem_req_w, valid_w;
  logic [31:0] flush_pc_w, data_w, mem_addr_w, pc_w, inst_w;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_flush_pc(flush_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .i_mem_ack(ack), .i_mem_data(data),
    .valid(valid), .pc(pc), .inst(inst), .i_ready(ready)
  );

  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .i_clk(clk), .i_rst(rst_w), .i_flush(flush_w), .i_flush_pc(flush_pc_w),
    .mem_req(mem_req_w), .mem_addr(mem_addr_w), .i_mem_ack(ack_w), .i_mem_data(data_w),
    .valid(valid_w), .pc(pc_w), .inst(inst_w), .i_ready(ready_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; flush_pc = '0; ack = 1'b0; data = '0; ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; ack = 1'b1; data = 32'h1111_2222; ready = 1'b1;
    #1;
    n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req got %b exp 0", mem_req); end
    n_chk++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", valid); end
    n_chk++; if (pc !== 32'h0 || inst !== 32'h0) begin n_fail++; $display("FAIL rst_head got pc %h inst %h exp 0/0", pc, inst); end
    @(negedge clk);
    n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_hold_req got %b exp 0", mem_req); end
    rst = 1'b0; ack = 1'b0;
    @(negedge clk);
    n_chk++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL first_req got %b exp 1", mem_req); end
    n_chk++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL first_addr got %h exp 0", mem_addr); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ready = 1'b1; ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      data = dat(32'(4 * k));
      n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'(4 * k)) begin
        n_fail++; $display("FAIL b2b_req k=%0d got %b/%h exp 1/%h", k, mem_req, mem_addr, 32'(4 * k)); end
      n_chk++; if (valid !== (k > 0)) begin n_fail++; $display("FAIL b2b_valid k=%0d got %b exp %b", k, valid, k > 0); end
      if (k > 0) begin
        n_chk++; if (pc !== 32'(4 * (k - 1)) || inst !== dat(32'(4 * (k - 1)))) begin
          n_fail++; $display("FAIL b2b_head k=%0d got %h/%h exp %h/%h", k, pc, inst, 32'(4 * (k - 1)), dat(32'(4 * (k - 1)))); end
      end
    end
  endtask

  task automatic test_full();
    logic [31:0] exp_pc;
    do_reset();
    ready = 1'b0; ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      data = dat(32'(4 * k));
      n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'(4 * k)) begin
        n_fail++; $display("FAIL full_req k=%0d got %b/%h exp 1/%h", k, mem_req, mem_addr, 32'(4 * k)); end
    end
    @(negedge clk);
    data = 32'hBAD0_0001;
    n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL full_req_drop got %b exp 0", mem_req); end
    n_chk++; if (valid !== 1'b1 || pc !== 32'h0 || inst !== dat(32'h0)) begin
      n_fail++; $display("FAIL full_head got %b/%h/%h exp 1/0/%h", valid, pc, inst, dat(32'h0)); end
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    n_chk++; if (mem_req !== 1'b0 || pc !== 32'h4) begin
      n_fail++; $display("FAIL full_after_pop got req %b pc %h exp 0/4", mem_req, pc); end
    @(negedge clk);
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
      n_fail++; $display("FAIL full_rereq got %b/%h exp 1/10", mem_req, mem_addr); end
    ack = 1'b0; ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      exp_pc = 32'(4 * k);
      n_chk++; if (valid !== 1'b1 || pc !== exp_pc || inst !== dat(exp_pc)) begin
        n_fail++; $display("FAIL full_drain k=%0d got %b/%h/%h exp 1/%h/%h", k, valid, pc, inst, exp_pc, dat(exp_pc)); end
      @(negedge clk);
    end
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL full_empty got %b exp 0", valid); end
  endtask

  task automatic test_flush_drop();
    do_reset();
    ready = 1'b0; ack = 1'b1;
    @(negedge clk); data = dat(32'h0);
    @(negedge clk); data = dat(32'h4);
    @(negedge clk);
    n_chk++; if (mem_addr !== 32'h8 || valid !== 1'b1) begin
      n_fail++; $display("FAIL drop_pre got addr %h valid %b exp 8/1", mem_addr, valid); end
    ack = 1'b0; flush = 1'b1; flush_pc = 32'h200;
    @(negedge clk);
    flush = 1'b0;
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h8 || valid !== 1'b0) begin
      n_fail++; $display("FAIL drop_hold got %b/%h/%b exp 1/8/0", mem_req, mem_addr, valid); end
    @(negedge clk);
    ack = 1'b1; data = 32'hDEAD_BEEF;
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin
      n_fail++; $display("FAIL drop_hold2 got %b/%h exp 1/8", mem_req, mem_addr); end
    @(negedge clk);
    ack = 1'b0;
    n_chk++; if (mem_req !== 1'b0 || valid !== 1'b0) begin
      n_fail++; $display("FAIL drop_discard got req %b valid %b exp 0/0", mem_req, valid); end
    @(negedge clk);
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h200 || valid !== 1'b0) begin
      n_fail++; $display("FAIL drop_redirect got %b/%h/%b exp 1/200/0", mem_req, mem_addr, valid); end
    ack = 1'b1; data = dat(32'h200);
    @(negedge clk);
    ack = 1'b0;
    n_chk++; if (valid !== 1'b1 || pc !== 32'h200 || inst !== dat(32'h200)) begin
      n_fail++; $display("FAIL drop_target got %b/%h/%h exp 1/200/%h", valid, pc, inst, dat(32'h200)); end
  endtask

  task automatic test_flush_pop();
    do_reset();
    ready = 1'b0; ack = 1'b1;
    @(negedge clk); data = dat(32'h0);
    @(negedge clk); data = dat(32'h4);
    @(negedge clk);
    n_chk++; if (valid !== 1'b1 || pc !== 32'h0) begin
      n_fail++; $display("FAIL fpop_pre got %b/%h exp 1/0", valid, pc); end
    ready = 1'b1; flush = 1'b1; flush_pc = 32'h100; data = 32'h1234_5678;
    @(negedge clk);
    flush = 1'b0; ready = 1'b0; ack = 1'b0;
    n_chk++; if (valid !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL fpop_clear got valid %b req %b exp 0/0", valid, mem_req); end
    @(negedge clk);
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || valid !== 1'b0) begin
      n_fail++; $display("FAIL fpop_redirect got %b/%h/%b exp 1/100/0", mem_req, mem_addr, valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready = 1'b0; ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); data = dat(32'(4 * k));
    end
    @(negedge clk);
    ack = 1'b0;
    n_chk++; if (valid !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'hC) begin
      n_fail++; $display("FAIL rmid_pre got %b/%b/%h exp 1/1/c", valid, mem_req, mem_addr); end
    #2 rst = 1'b1;
    #1;
    n_chk++; if (valid !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h0 || pc !== 32'h0) begin
      n_fail++; $display("FAIL rmid_async got %b/%b/%h/%h exp 0/0/0/0", valid, mem_req, mem_addr, pc); end
    @(negedge clk);
    rst = 1'b0; ack = 1'b1; data = 32'hBAD0_BAD0;
    @(negedge clk);
    ack = 1'b0;
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || valid !== 1'b0) begin
      n_fail++; $display("FAIL rmid_restart got %b/%h/%b exp 1/0/0", mem_req, mem_addr, valid); end
    @(negedge clk);
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rmid_late_ack got valid %b exp 0", valid); end
  endtask

  task automatic test_wrap();
    logic [31:0] ea;
    logic [31:0] ep;
    @(negedge clk);
    ack_w = 1'b1; ready_w = 1'b1; rst_w = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ea = 32'hFFFF_FFF8 + 32'(4 * k);
      ep = 32'hFFFF_FFF8 + 32'(4 * (k - 1));
      data_w = dat(ea);
      n_chk++; if (mem_req_w !== 1'b1 || mem_addr_w !== ea) begin
        n_fail++; $display("FAIL wrap_addr k=%0d got %b/%h exp 1/%h", k, mem_req_w, mem_addr_w, ea); end
      if (k > 0) begin
        n_chk++; if (valid_w !== 1'b1 || pc_w !== ep || inst_w !== dat(ep)) begin
          n_fail++; $display("FAIL wrap_head k=%0d got %b/%h/%h exp 1/%h/%h", k, valid_w, pc_w, inst_w, ep, dat(ep)); end
      end
    end
    ack_w = 1'b0;
  endtask

  task automatic test_random();
    ent_t        q[$];
    logic        m_req, m_drop, pop;
    logic [31:0] m_addr, m_next, exp_pc, exp_inst;
    int          sz0;
    do_reset();
    q.delete(); m_req = 1'b0; m_drop = 1'b0; m_addr = '0; m_next = 32'h0;
    for (int i = 0; i < 1500; i++) begin
      ack   = ($urandom_range(0, 1) == 1);
      ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 19) == 0);
      flush_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      data  = ($urandom_range(0, 3) == 0) ? NOP_INST : $urandom();
      exp_pc   = (q.size() != 0) ? q[0].pc : 32'h0;
      exp_inst = (q.size() != 0) ? q[0].inst : 32'h0;
      n_chk++; if (mem_req !== m_req) begin n_fail++; $display("FAIL rnd_req cyc=%0d got %b exp %b", i, mem_req, m_req); end
      if (m_req) begin
        n_chk++; if (mem_addr !== m_addr) begin n_fail++; $display("FAIL rnd_addr cyc=%0d got %h exp %h", i, mem_addr, m_addr); end
      end
      n_chk++; if (valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got %b exp %b", i, valid, q.size() != 0); end
      n_chk++; if (pc !== exp_pc) begin n_fail++; $display("FAIL rnd_pc cyc=%0d got %h exp %h", i, pc, exp_pc); end
      n_chk++; if (inst !== exp_inst) begin n_fail++; $display("FAIL rnd_inst cyc=%0d got %h exp %h", i, inst, exp_inst); end
      @(posedge clk);
      sz0 = q.size();
      pop = (sz0 != 0) && ready && !flush;
      if (flush) begin
        q.delete();
        m_next = flush_pc;
        if (m_req) begin
          if (ack) begin m_req = 1'b0; m_drop = 1'b0; end
          else m_drop = 1'b1;
        end
      end else begin
        if (pop) void'(q.pop_front());
        if (m_req && ack) begin
          if (m_drop) begin
            m_req = 1'b0; m_drop = 1'b0;
          end else begin
            q.push_back('{pc: m_addr, inst: data});
            if (q.size() < DEPTH) begin m_addr = m_next; m_next = m_next + 32'd4; end
            else m_req = 1'b0;
          end
        end else if (!m_req && sz0 < DEPTH) begin
          m_req = 1'b1; m_addr = m_next; m_next = m_next + 32'd4;
        end
      end
      @(negedge clk);
    end
    flush = 1'b0; ack = 1'b0; ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; flush_pc = '0; ack = 1'b0; data = '0; ready = 1'b0;
    rst_w = 1'b1; flush_w = 1'b0; flush_pc_w = '0; ack_w = 1'b0; data_w = '0; ready_w = 1'b0;
    test_reset();
    test_back_to_back();
    test_full();
    test_flush_drop();
    test_flush_pop();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
